avalon_register_bridge: RTL and testbench

//  Avalon-MM slave to peripheral register-bank bridge. Parametrised data width, register count and read latency.

---
 rtl/avalon_pkg.sv | 21 ++
 rtl/avalon_cmd_pipe.sv | 71 +++++++
 rtl/avalon_register_bridge.sv | 145 ++++++++++++++
 tb/tb_avalon_register_bridge.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared types for the Avalon-MM register bridge: response codes, per-command flags
// and the saturating error-counter increment.
package avalon_pkg;

    typedef enum logic [1:0] {
        AVS_OKAY   = 2'b00,
        AVS_SLVERR = 2'b10
    } avs_resp_t;

    // Width-independent part of a pipeline-stage entry; addr/be/wdata ride alongside.
    typedef struct packed {
        logic is_wr;
        logic oor;
        logic rw_both;
    } stage_flags_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/avalon_cmd_pipe.sv
// Fixed-length shift pipeline of accepted commands. Only the valid bits are reset;
// the payload is don't-care whenever its valid bit is low.
module avalon_cmd_pipe
    import avalon_pkg::*;
#(
    parameter int unsigned DEPTH      = 1,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned BE_WIDTH   = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  stage_flags_t          in_flags,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [BE_WIDTH-1:0]   in_be,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    output logic                  out_valid,
    output stage_flags_t          out_flags,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [BE_WIDTH-1:0]   out_be,
    output logic [DATA_WIDTH-1:0] out_wdata
);

    typedef struct packed {
        stage_flags_t          flags;
        logic [ADDR_WIDTH-1:0] addr;
        logic [BE_WIDTH-1:0]   be;
        logic [DATA_WIDTH-1:0] wdata;
    } payload_t;

    payload_t in_payload;
    payload_t out_payload;

    assign in_payload = '{flags: in_flags, addr: in_addr, be: in_be, wdata: in_wdata};

    if (DEPTH == 0) begin : g_bypass
        assign out_valid   = in_valid;
        assign out_payload = in_payload;
    end else begin : g_stages
        logic [DEPTH-1:0] valid_q;
        payload_t         payload_q [DEPTH];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                valid_q <= '0;
            end else begin
                valid_q[0] <= in_valid;
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            payload_q[0] <= in_payload;
            for (int i = 1; i < DEPTH; i++) begin
                payload_q[i] <= payload_q[i-1];
            end
        end

        assign out_valid   = valid_q[DEPTH-1];
        assign out_payload = payload_q[DEPTH-1];
    end

    assign out_flags = out_payload.flags;
    assign out_addr  = out_payload.addr;
    assign out_be    = out_payload.be;
    assign out_wdata = out_payload.wdata;

endmodule

// File: rtl/avalon_register_bridge.sv
// Avalon-MM slave to peripheral register bank: fixed-latency command pipeline, one-hot
// register strobes, read mux, read/write responses and a saturating error counter.
module avalon_register_bridge
    import avalon_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_REGS     = 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_WIDTH   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    parameter int unsigned BE_WIDTH     = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           avs_read,
    input  logic                           avs_write,
    input  logic [ADDR_WIDTH-1:0]          avs_address,
    input  logic [BE_WIDTH-1:0]            avs_byteenable,
    input  logic [DATA_WIDTH-1:0]          avs_writedata,
    output logic                           avs_waitrequest,
    output logic [DATA_WIDTH-1:0]          avs_readdata,
    output logic                           avs_readdatavalid,
    output logic                           avs_writeresponsevalid,
    output logic [1:0]                     avs_response,
    input  logic                           reg_busy,
    output logic [NUM_REGS-1:0]            reg_write_en,
    output logic [NUM_REGS-1:0]            reg_read_en,
    output logic [BE_WIDTH-1:0]            reg_byteen,
    output logic [DATA_WIDTH-1:0]          reg_wdata,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_rdata,
    output logic [15:0]                    err_count
);

    localparam int unsigned PipeDepth = READ_LATENCY - 1;

    logic                  acc_valid;
    stage_flags_t          acc_flags;
    logic                  acc_oor;

    logic                  st_valid;
    stage_flags_t          st_flags;
    logic [ADDR_WIDTH-1:0] st_addr;
    logic [BE_WIDTH-1:0]   st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic                  st_strobe;
    logic                  st_bad;
    logic [DATA_WIDTH-1:0] rd_word;

    logic                  rd_valid_q;
    logic                  wr_valid_q;
    avs_resp_t             resp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [15:0]           err_count_q;

    assign avs_waitrequest = reg_busy;
    // Gating with reset keeps the zero-depth (L=1) strobe quiet while reset is held.
    assign acc_valid = (avs_read | avs_write) & ~reg_busy & ~reset;

    if (NUM_REGS < (2 ** ADDR_WIDTH)) begin : g_range_check
        assign acc_oor = (avs_address >= ADDR_WIDTH'(NUM_REGS));
    end else begin : g_full_range
        assign acc_oor = 1'b0;
    end

    always_comb begin
        acc_flags         = '0;
        acc_flags.is_wr   = avs_write;
        acc_flags.oor     = acc_oor;
        acc_flags.rw_both = avs_read & avs_write;
    end

    avalon_cmd_pipe #(
        .DEPTH      (PipeDepth),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BE_WIDTH   (BE_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cmd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (acc_valid),
        .in_flags  (acc_flags),
        .in_addr   (avs_address),
        .in_be     (avs_byteenable),
        .in_wdata  (avs_writedata),
        .out_valid (st_valid),
        .out_flags (st_flags),
        .out_addr  (st_addr),
        .out_be    (st_be),
        .out_wdata (st_wdata)
    );

    assign st_strobe = st_valid & ~st_flags.oor;
    assign st_bad    = st_flags.oor | st_flags.rw_both;

    always_comb begin
        reg_write_en = '0;
        reg_read_en  = '0;
        if (st_strobe) begin
            if (st_flags.is_wr) begin
                reg_write_en[st_addr] = 1'b1;
            end else begin
                reg_read_en[st_addr] = 1'b1;
            end
        end
    end

    assign reg_byteen = st_strobe ? st_be : '0;
    assign reg_wdata  = st_strobe ? st_wdata : '0;

    // Out-of-range addresses match no entry and therefore read as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (st_addr == ADDR_WIDTH'(i)) begin
                rd_word = reg_rdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            resp_q      <= AVS_OKAY;
            rdata_q     <= '0;
            err_count_q <= '0;
        end else begin
            rd_valid_q <= st_valid & ~st_flags.is_wr;
            wr_valid_q <= st_valid & st_flags.is_wr;
            resp_q     <= (st_valid && st_bad) ? AVS_SLVERR : AVS_OKAY;
            if (st_valid && !st_flags.is_wr) begin
                rdata_q <= rd_word;
            end
            if (st_valid && st_bad) begin
                err_count_q <= sat_inc16(err_count_q);
            end
        end
    end

    assign avs_readdatavalid      = rd_valid_q;
    assign avs_writeresponsevalid = wr_valid_q;
    assign avs_response           = resp_q;
    assign avs_readdata           = rdata_q;
    assign err_count              = err_count_q;

endmodule

// File: tb/tb_avalon_register_bridge.sv
// Bench for the register bridge: directed scenarios on an 8-register L=2 bridge and a
// 5-register L=3 bridge, plus randomized traffic checked against a per-cycle model.
module tb_avalon_register_bridge;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Bridge A: 8 registers, latency 2
    logic         a_read, a_write, a_busy, a_wait, a_rdv, a_wrv;
    logic [2:0]   a_addr;
    logic [3:0]   a_be, a_rbe;
    logic [31:0]  a_wdata, a_rdata, a_rwd;
    logic [1:0]   a_resp;
    logic [7:0]   a_wen, a_ren;
    logic [255:0] a_regs;
    logic [15:0]  a_errc;

    // Bridge B: 5 registers (out-of-range addresses exist), latency 3
    logic         b_read, b_write, b_busy, b_wait, b_rdv, b_wrv;
    logic [2:0]   b_addr;
    logic [3:0]   b_be, b_rbe;
    logic [31:0]  b_wdata, b_rdata, b_rwd;
    logic [1:0]   b_resp;
    logic [4:0]   b_wen, b_ren;
    logic [159:0] b_regs;
    logic [15:0]  b_errc;

    avalon_register_bridge #(
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .READ_LATENCY (2)
    ) dut_a (
        .clk (clk), .reset (reset),
        .avs_read (a_read), .avs_write (a_write), .avs_address (a_addr),
        .avs_byteenable (a_be), .avs_writedata (a_wdata), .avs_waitrequest (a_wait),
        .avs_readdata (a_rdata), .avs_readdatavalid (a_rdv),
        .avs_writeresponsevalid (a_wrv), .avs_response (a_resp),
        .reg_busy (a_busy), .reg_write_en (a_wen), .reg_read_en (a_ren),
        .reg_byteen (a_rbe), .reg_wdata (a_rwd), .reg_rdata (a_regs), .err_count (a_errc)
    );

    avalon_register_bridge #(
        .DATA_WIDTH (32),
        .NUM_REGS   (5),
        .READ_LATENCY (3)
    ) dut_b (
        .clk (clk), .reset (reset),
        .avs_read (b_read), .avs_write (b_write), .avs_address (b_addr),
        .avs_byteenable (b_be), .avs_writedata (b_wdata), .avs_waitrequest (b_wait),
        .avs_readdata (b_rdata), .avs_readdatavalid (b_rdv),
        .avs_writeresponsevalid (b_wrv), .avs_response (b_resp),
        .reg_busy (b_busy), .reg_write_en (b_wen), .reg_read_en (b_ren),
        .reg_byteen (b_rbe), .reg_wdata (b_rwd), .reg_rdata (b_regs), .err_count (b_errc)
    );

    task automatic test_reset();
        reset = 1'b1;
        a_read = 0; a_write = 0; a_busy = 0; a_addr = 0; a_be = 0; a_wdata = 0;
        b_read = 0; b_write = 0; b_busy = 0; b_addr = 0; b_be = 0; b_wdata = 0;
        for (int i = 0; i < 8; i++) a_regs[i*32 +: 32] = 32'(i + 100);
        for (int i = 0; i < 5; i++) b_regs[i*32 +: 32] = 32'hB000_0000 + 32'(i);
        @(negedge clk);
        #1;
        n_vec++;
        if ({a_wait, a_rdv, a_wrv, a_resp, a_rdata, a_wen, a_ren, a_rbe, a_rwd, a_errc} !== '0)
        begin
            n_err++;
            $display("FAIL reset_a got %h want 0",
                     {a_wait, a_rdv, a_wrv, a_resp, a_rdata, a_wen, a_ren, a_rbe, a_rwd, a_errc});
        end
        n_vec++;
        if ({b_wait, b_rdv, b_wrv, b_resp, b_rdata, b_wen, b_ren, b_rbe, b_rwd, b_errc} !== '0)
        begin
            n_err++;
            $display("FAIL reset_b got %h want 0",
                     {b_wait, b_rdv, b_wrv, b_resp, b_rdata, b_wen, b_ren, b_rbe, b_rwd, b_errc});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write();
        @(negedge clk);
        a_write = 1; a_addr = 3; a_wdata = 32'hDEADBEEF; a_be = 4'hF;
        #1;
        n_vec++;
        if (a_wait !== 1'b0) begin n_err++; $display("FAIL wr_wait got %b want 0", a_wait); end
        @(negedge clk);
        a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        #1;
        n_vec++;
        if (a_wen !== 8'h08 || a_ren !== 8'h00) begin
            n_err++; $display("FAIL wr_strobe got wen=%h ren=%h want 08/00", a_wen, a_ren);
        end
        n_vec++;
        if (a_rwd !== 32'hDEADBEEF || a_rbe !== 4'hF || a_wrv !== 1'b0) begin
            n_err++;
            $display("FAIL wr_payload got wd=%h be=%h wrv=%b want deadbeef/f/0", a_rwd, a_rbe, a_wrv);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (a_wrv !== 1'b1 || a_resp !== 2'b00 || a_rdv !== 1'b0) begin
            n_err++;
            $display("FAIL wr_resp got wrv=%b resp=%b rdv=%b want 1/00/0", a_wrv, a_resp, a_rdv);
        end
        n_vec++;
        if (a_wen !== 8'h00 || a_rwd !== 32'h0 || a_rbe !== 4'h0) begin
            n_err++; $display("FAIL wr_idle got wen=%h wd=%h be=%h want 0", a_wen, a_rwd, a_rbe);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (a_wrv !== 1'b0) begin n_err++; $display("FAIL wr_once got %b want 0", a_wrv); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  exp_ren;
        logic [31:0] exp_data;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_read = (k < 3);
            a_addr = 3'(k);
            #1;
            exp_ren = (k >= 1 && k <= 3) ? 8'(1 << (k - 1)) : 8'h00;
            n_vec++;
            if (a_ren !== exp_ren) begin
                n_err++; $display("FAIL b2b_ren k=%0d got %h want %h", k, a_ren, exp_ren);
            end
            n_vec++;
            if (a_rdv !== (k >= 2 && k <= 4)) begin
                n_err++; $display("FAIL b2b_rdv k=%0d got %b", k, a_rdv);
            end
            if (k >= 2) begin
                exp_data = 32'(100 + ((k > 4) ? 4 : k) - 2);
                n_vec++;
                if (a_rdata !== exp_data) begin
                    n_err++; $display("FAIL b2b_data k=%0d got %0d want %0d", k, a_rdata, exp_data);
                end
            end
        end
        a_read = 0;
    endtask

    task automatic test_busy();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            a_busy = (k < 3);
            a_read = (k <= 3);
            a_addr = 3'd5;
            #1;
            n_vec++;
            if (a_wait !== (k < 3)) begin
                n_err++; $display("FAIL busy_wait k=%0d got %b", k, a_wait);
            end
            n_vec++;
            if (a_ren !== ((k == 4) ? 8'h20 : 8'h00)) begin
                n_err++; $display("FAIL busy_ren k=%0d got %h", k, a_ren);
            end
            n_vec++;
            if (a_rdv !== (k == 5)) begin
                n_err++; $display("FAIL busy_rdv k=%0d got %b", k, a_rdv);
            end
        end
        n_vec++;
        if (a_rdata !== 32'd105) begin
            n_err++; $display("FAIL busy_data got %0d want 105", a_rdata);
        end
        a_read = 0; a_busy = 0;
    endtask

    task automatic test_rw_both();
        @(negedge clk);
        a_read = 1; a_write = 1; a_addr = 1; a_wdata = 32'h1234_5678; a_be = 4'h3;
        @(negedge clk);
        a_read = 0; a_write = 0; a_addr = 0; a_wdata = 0; a_be = 0;
        #1;
        n_vec++;
        if (a_wen !== 8'h02 || a_ren !== 8'h00 || a_rbe !== 4'h3 || a_rwd !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL rw_strobe got wen=%h ren=%h be=%h wd=%h", a_wen, a_ren, a_rbe, a_rwd);
        end
        @(negedge clk);
        #1;
        n_vec++;
        if (a_wrv !== 1'b1 || a_rdv !== 1'b0 || a_resp !== 2'b10 || a_errc !== 16'd1) begin
            n_err++;
            $display("FAIL rw_resp got wrv=%b rdv=%b resp=%b err=%0d want 1/0/10/1",
                     a_wrv, a_rdv, a_resp, a_errc);
        end
    endtask

    task automatic test_reset_in_flight();
        @(negedge clk);
        a_read = 1; a_addr = 0;
        @(negedge clk);
        a_addr = 1;
        #1;
        n_vec++;
        if (a_ren !== 8'h01) begin n_err++; $display("FAIL rif_pre got %h want 01", a_ren); end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({a_wait, a_rdv, a_wrv, a_resp, a_rdata, a_wen, a_ren, a_rbe, a_rwd, a_errc} !== '0)
        begin
            n_err++;
            $display("FAIL rif_zero got %h want 0",
                     {a_wait, a_rdv, a_wrv, a_resp, a_rdata, a_wen, a_ren, a_rbe, a_rwd, a_errc});
        end
        a_read = 0; a_addr = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (a_rdv !== 1'b0 || a_wrv !== 1'b0 || a_ren !== 8'h00) begin
                n_err++; $display("FAIL rif_quiet k=%0d got rdv=%b wrv=%b ren=%h", k, a_rdv, a_wrv, a_ren);
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b_read = (k < 2);
            b_addr = (k == 0) ? 3'd2 : 3'd6;
            #1;
            n_vec++;
            if (b_ren !== ((k == 2) ? 5'b00100 : 5'b00000) || b_wen !== 5'b0) begin
                n_err++; $display("FAIL oor_strobe k=%0d got ren=%b wen=%b", k, b_ren, b_wen);
            end
            n_vec++;
            if (b_rdv !== (k == 3 || k == 4)) begin
                n_err++; $display("FAIL oor_rdv k=%0d got %b", k, b_rdv);
            end
            if (k == 3) begin
                n_vec++;
                if (b_rdata !== 32'hB000_0002 || b_resp !== 2'b00 || b_errc !== 16'd0) begin
                    n_err++;
                    $display("FAIL oor_good got d=%h resp=%b err=%0d", b_rdata, b_resp, b_errc);
                end
            end
            if (k == 4) begin
                n_vec++;
                if (b_rdata !== 32'h0 || b_resp !== 2'b10 || b_errc !== 16'd1) begin
                    n_err++;
                    $display("FAIL oor_bad got d=%h resp=%b err=%0d want 0/10/1",
                             b_rdata, b_resp, b_errc);
                end
            end
        end
        b_read = 0;
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut_b.err_count_q = 16'hFFFE;
        #1;
        release dut_b.err_count_q;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b_read = (k < 2);
            b_addr = 3'd7;
            #1;
            if (k == 0) begin
                n_vec++;
                if (b_errc !== 16'hFFFE) begin
                    n_err++; $display("FAIL sat_pre got %h want fffe", b_errc);
                end
            end
            if (k >= 3) begin
                n_vec++;
                if (b_errc !== 16'hFFFF) begin
                    n_err++; $display("FAIL sat_hold k=%0d got %h want ffff", k, b_errc);
                end
            end
        end
        b_read = 0;
    endtask

    task automatic test_random();
        localparam int N = 300;
        localparam int L = 3;
        bit          av [N+8];
        bit          aw [N+8];
        bit          arw [N+8];
        int          aa [N+8];
        logic [3:0]  ab [N+8];
        logic [31:0] ad [N+8];
        logic [31:0] rm [5];
        logic [4:0]  exp_wen, exp_ren;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd = 32'h0;
        logic        exp_rdv, exp_wrv;
        logic [1:0]  exp_resp;
        int          exp_err = 0;
        int          s, r, op;
        bit          bad;

        for (int i = 0; i < 5; i++) begin
            rm[i] = $urandom;
            b_regs[i*32 +: 32] = rm[i];
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int c = 0; c < N + L + 1; c++) begin
            @(negedge clk);
            exp_wen = '0; exp_ren = '0; exp_be = '0; exp_wd = '0;
            s = c - (L - 1);
            if (s >= 0 && av[s] && aa[s] < 5) begin
                if (aw[s]) exp_wen = 5'(1 << aa[s]);
                else       exp_ren = 5'(1 << aa[s]);
                exp_be = ab[s];
                exp_wd = ad[s];
            end
            exp_rdv = 0; exp_wrv = 0; exp_resp = 2'b00;
            r = c - L;
            if (r >= 0 && av[r]) begin
                bad = (aa[r] >= 5) || arw[r];
                exp_resp = bad ? 2'b10 : 2'b00;
                if (aw[r]) begin
                    exp_wrv = 1;
                end else begin
                    exp_rdv = 1;
                    exp_rd = (aa[r] < 5) ? rm[aa[r]] : 32'h0;
                end
                if (bad && exp_err < 65535) exp_err++;
            end
            n_vec++;
            if (b_wen !== exp_wen || b_ren !== exp_ren) begin
                n_err++;
                $display("FAIL rnd_strobe c=%0d got wen=%b ren=%b want %b/%b",
                         c, b_wen, b_ren, exp_wen, exp_ren);
            end
            n_vec++;
            if (b_rbe !== exp_be || b_rwd !== exp_wd) begin
                n_err++;
                $display("FAIL rnd_payload c=%0d got be=%h wd=%h want %h/%h",
                         c, b_rbe, b_rwd, exp_be, exp_wd);
            end
            n_vec++;
            if (b_rdv !== exp_rdv || b_wrv !== exp_wrv || b_resp !== exp_resp) begin
                n_err++;
                $display("FAIL rnd_resp c=%0d got rdv=%b wrv=%b resp=%b want %b/%b/%b",
                         c, b_rdv, b_wrv, b_resp, exp_rdv, exp_wrv, exp_resp);
            end
            n_vec++;
            if (b_rdata !== exp_rd) begin
                n_err++; $display("FAIL rnd_rdata c=%0d got %h want %h", c, b_rdata, exp_rd);
            end
            n_vec++;
            if (b_errc !== 16'(exp_err)) begin
                n_err++; $display("FAIL rnd_errc c=%0d got %0d want %0d", c, b_errc, exp_err);
            end

            if (c < N) begin
                op      = int'($urandom_range(0, 7));
                b_read  = (op >= 2 && op <= 4) || op == 7;
                b_write = (op == 5 || op == 6 || op == 7);
                b_busy  = ($urandom_range(0, 3) == 0);
                b_addr  = 3'($urandom_range(0, 7));
                b_be    = 4'($urandom);
                b_wdata = $urandom;
            end else begin
                b_read = 0; b_write = 0; b_busy = 0; b_addr = 0; b_be = 0; b_wdata = 0;
            end
            av[c]  = (b_read || b_write) && !b_busy;
            aw[c]  = b_write;
            arw[c] = b_read && b_write;
            aa[c]  = int'(b_addr);
            ab[c]  = b_be;
            ad[c]  = b_wdata;
            #1;
            n_vec++;
            if (b_wait !== b_busy) begin
                n_err++; $display("FAIL rnd_wait c=%0d got %b want %b", c, b_wait, b_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_busy();
        test_rw_both();
        test_reset_in_flight();
        test_out_of_range();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
